sprite_mover: RTL and testbench

Parametrised successor to the single-speed keyboard ball. It moves one square sprite one step per frame_clk from the WASD/space keycode. Speed accelerates while a direction key is held, the sprite coasts when the key is released, and it stops on space. Edge hits clamp and reflect cleanly, with no overshoot, and raise a one-frame bounce pulse. Its outputs feed the colour mapper and game logic in the USB + HDMI design.

---
 rtl/sprite_mover.sv | 94 +++++++++
 tb/tb_sprite_mover.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sprite_mover.sv
// sprite_mover: keyboard-driven square sprite with acceleration, coasting, stop and clamped edge reflection.
module sprite_mover #(
  parameter int X_MIN = 0,
  parameter int X_MAX = 639,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 479,
  parameter int X_CENTER = 320,
  parameter int Y_CENTER = 240,
  parameter int SIZE = 16,
  parameter int MAX_SPEED = 4,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic [9:0] SpriteX,
  output logic [9:0] SpriteY,
  output logic [9:0] SpriteS,
  output logic       Moving,
  output logic       Bounce,
  output logic [3:0] Speed
);
  typedef enum logic {STOPPED, MOVING} state_t;
  localparam logic [7:0] K_W = 8'h1A, K_S = 8'h16, K_A = 8'h04, K_D = 8'h07, K_SP = 8'h2C;
  state_t state, state_n;
  logic signed [1:0] dx, dy, dx_n, dy_n;
  logic [3:0] spd_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0] last, last_n;
  logic dir, press;
  logic signed [11:0] step_x, step_y, nx, ny;
  logic hit_r, hit_l, hit_d, hit_u;
  assign SpriteS = 10'(SIZE);
  always_comb begin
    dir = keycode == K_W || keycode == K_S || keycode == K_A || keycode == K_D;
    press = dir && (keycode != last || state == STOPPED);
    dx_n = dx;
    dy_n = dy;
    spd_n = Speed;
    cnt_n = cnt;
    state_n = state;
    last_n = dir ? keycode : 8'h00;
    if (keycode == K_SP) begin
      dx_n = 2'sb00;
      dy_n = 2'sb00;
      spd_n = 4'd0;
      cnt_n = 16'd0;
      state_n = STOPPED;
    end else if (press) begin
      dx_n = keycode == K_D ? 2'sb01 : keycode == K_A ? 2'sb11 : 2'sb00;
      dy_n = keycode == K_S ? 2'sb01 : keycode == K_W ? 2'sb11 : 2'sb00;
      spd_n = 4'd1;
      cnt_n = 16'd0;
      state_n = MOVING;
    end else if (dir) begin
      spd_n = cnt == 16'(ACCEL_FRAMES - 1) && Speed != 4'(MAX_SPEED) ? Speed + 4'd1 : Speed;
      cnt_n = cnt == 16'(ACCEL_FRAMES - 1) ? 16'd0 : cnt + 16'd1;
    end
    // Motion uses the direction and speed chosen this same frame
    step_x = dx_n == 2'sb01 ? {8'b0, spd_n} : dx_n == 2'sb11 ? -{8'b0, spd_n} : 12'sd0;
    step_y = dy_n == 2'sb01 ? {8'b0, spd_n} : dy_n == 2'sb11 ? -{8'b0, spd_n} : 12'sd0;
    nx = $signed({2'b00, SpriteX}) + step_x;
    ny = $signed({2'b00, SpriteY}) + step_y;
    hit_r = dx_n == 2'sb01 && nx + SIZE > X_MAX;
    hit_l = dx_n == 2'sb11 && nx - SIZE < X_MIN;
    hit_d = dy_n == 2'sb01 && ny + SIZE > Y_MAX;
    hit_u = dy_n == 2'sb11 && ny - SIZE < Y_MIN;
  end
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      SpriteX <= 10'(X_CENTER);
      SpriteY <= 10'(Y_CENTER);
      dx <= 2'sb00;
      dy <= 2'sb00;
      Speed <= 4'd0;
      cnt <= 16'd0;
      last <= 8'h00;
      state <= STOPPED;
      Moving <= 1'b0;
      Bounce <= 1'b0;
    end else begin
      SpriteX <= hit_r ? 10'(X_MAX - SIZE) : hit_l ? 10'(X_MIN + SIZE) : nx[9:0];
      SpriteY <= hit_d ? 10'(Y_MAX - SIZE) : hit_u ? 10'(Y_MIN + SIZE) : ny[9:0];
      dx <= hit_r ? 2'sb11 : hit_l ? 2'sb01 : dx_n;
      dy <= hit_d ? 2'sb11 : hit_u ? 2'sb01 : dy_n;
      Speed <= spd_n;
      cnt <= cnt_n;
      last <= last_n;
      state <= state_n;
      Moving <= state_n == MOVING;
      Bounce <= hit_r || hit_l || hit_d || hit_u;
    end
  end
endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: directed and randomized checks of sprite_mover against a frame-level reference model.
module tb_sprite_mover;
  logic frame_clk = 0, Reset = 1;
  logic [7:0] keycode = 0;
  logic [9:0] SpriteX, SpriteY, SpriteS;
  logic Moving, Bounce;
  logic [3:0] Speed;
  int total = 0, bad = 0;
  int mx, my, mdx, mdy, msp, mcnt, mlast, mmov, mbnc;

  sprite_mover dut (.frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .SpriteX(SpriteX),
    .SpriteY(SpriteY), .SpriteS(SpriteS), .Moving(Moving), .Bounce(Bounce), .Speed(Speed));

  always #5 frame_clk = ~frame_clk;

  function automatic void model(input logic [7:0] k, input bit r);
    bit d;
    if (r) begin
      mx = 320; my = 240; mdx = 0; mdy = 0; msp = 0; mcnt = 0; mlast = 0; mmov = 0; mbnc = 0;
      return;
    end
    d = k == 8'h1A || k == 8'h16 || k == 8'h04 || k == 8'h07;
    mbnc = 0;
    if (k == 8'h2C) begin
      mdx = 0; mdy = 0; msp = 0; mcnt = 0; mmov = 0;
    end else if (d && (int'(k) != mlast || mmov == 0)) begin
      mdx = k == 8'h07 ? 1 : k == 8'h04 ? -1 : 0;
      mdy = k == 8'h16 ? 1 : k == 8'h1A ? -1 : 0;
      msp = 1; mcnt = 0; mmov = 1;
    end else if (d) begin
      if (mcnt == 7) begin
        msp = msp < 4 ? msp + 1 : 4;
        mcnt = 0;
      end else mcnt++;
    end
    mlast = d ? int'(k) : 0;
    mx += mdx * msp;
    my += mdy * msp;
    if (mdx == 1 && mx + 16 > 639) begin mx = 623; mdx = -1; mbnc = 1; end
    if (mdx == -1 && mx - 16 < 0) begin mx = 16; mdx = 1; mbnc = 1; end
    if (mdy == 1 && my + 16 > 479) begin my = 463; mdy = -1; mbnc = 1; end
    if (mdy == -1 && my - 16 < 0) begin my = 16; mdy = 1; mbnc = 1; end
  endfunction

  task automatic step(input logic [7:0] k, input bit r = 0);
    keycode = k;
    Reset = r;
    @(posedge frame_clk);
    #1;
    model(k, r);
  endtask

  task automatic do_reset();
    step(8'h00, 1);
    step(8'h00, 1);
    Reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({SpriteX, SpriteY, SpriteS} !== {10'd320, 10'd240, 10'd16}) begin bad++; $display("FAIL reset_pos x=%0d y=%0d s=%0d want 320 240 16", SpriteX, SpriteY, SpriteS); end
    total++; if ({Speed, Moving, Bounce} !== 6'b0) begin bad++; $display("FAIL reset_flags speed=%0d mov=%0b bnc=%0b want 0 0 0", Speed, Moving, Bounce); end
  endtask

  task automatic test_accel();
    do_reset();
    step(8'h07);
    total++; if (SpriteX !== 10'd321 || Speed !== 4'd1 || Moving !== 1'b1) begin bad++; $display("FAIL accel_e1 x=%0d sp=%0d mov=%0b want 321 1 1", SpriteX, Speed, Moving); end
    for (int i = 0; i < 7; i++) step(8'h07);
    total++; if (SpriteX !== 10'd328 || Speed !== 4'd1) begin bad++; $display("FAIL accel_e8 x=%0d sp=%0d want 328 1", SpriteX, Speed); end
    step(8'h07);
    total++; if (SpriteX !== 10'd330 || Speed !== 4'd2) begin bad++; $display("FAIL accel_e9 x=%0d sp=%0d want 330 2", SpriteX, Speed); end
    for (int i = 0; i < 24; i++) step(8'h07);
    total++; if (Speed !== 4'd4 || SpriteX !== 10'(mx)) begin bad++; $display("FAIL accel_sat sp=%0d x=%0d want 4 %0d", Speed, SpriteX, mx); end
    for (int i = 0; i < 10; i++) step(8'h07);
    total++; if (Speed !== 4'd4 || SpriteX !== 10'(mx)) begin bad++; $display("FAIL accel_hold sp=%0d x=%0d want 4 %0d", Speed, SpriteX, mx); end
  endtask

  task automatic test_coast_stop();
    logic [9:0] x0;
    do_reset();
    for (int i = 0; i < 12; i++) step(8'h07);
    x0 = SpriteX;
    step(8'h00);
    step(8'h00);
    total++; if (SpriteX !== x0 + 10'd4 || Moving !== 1'b1 || Speed !== 4'd2) begin bad++; $display("FAIL coast x=%0d mov=%0b sp=%0d want %0d 1 2", SpriteX, Moving, Speed, x0 + 10'd4); end
    x0 = SpriteX;
    step(8'h2C);
    step(8'h00);
    total++; if (SpriteX !== x0 || Speed !== 4'd0 || Moving !== 1'b0) begin bad++; $display("FAIL stop x=%0d sp=%0d mov=%0b want %0d 0 0", SpriteX, Speed, Moving, x0); end
  endtask

  task automatic test_right_bounce();
    do_reset();
    for (int i = 0; i < 9; i++) step(8'h07);
    for (int i = 0; i < 146; i++) step(8'h00);
    total++; if (SpriteX !== 10'd622 || Bounce !== 1'b0) begin bad++; $display("FAIL rb_pre x=%0d bnc=%0b want 622 0", SpriteX, Bounce); end
    step(8'h00);
    total++; if (SpriteX !== 10'd623 || Bounce !== 1'b1) begin bad++; $display("FAIL rb_hit x=%0d bnc=%0b want 623 1", SpriteX, Bounce); end
    step(8'h00);
    total++; if (SpriteX !== 10'd621 || Bounce !== 1'b0 || Speed !== 4'd2) begin bad++; $display("FAIL rb_after x=%0d bnc=%0b sp=%0d want 621 0 2", SpriteX, Bounce, Speed); end
  endtask

  task automatic test_turns();
    do_reset();
    for (int i = 0; i < 17; i++) step(8'h07);
    total++; if (SpriteX !== 10'd347 || Speed !== 4'd3) begin bad++; $display("FAIL turn_pre x=%0d sp=%0d want 347 3", SpriteX, Speed); end
    step(8'h1A);
    total++; if ({SpriteX, SpriteY, Speed} !== {10'd347, 10'd239, 4'd1}) begin bad++; $display("FAIL turn_up x=%0d y=%0d sp=%0d want 347 239 1", SpriteX, SpriteY, Speed); end
    step(8'h04);
    total++; if ({SpriteX, SpriteY, Speed} !== {10'd346, 10'd239, 4'd1}) begin bad++; $display("FAIL turn_left x=%0d y=%0d sp=%0d want 346 239 1", SpriteX, SpriteY, Speed); end
    step(8'h00);
    step(8'h04);
    total++; if (SpriteX !== 10'd344 || Speed !== 4'd1) begin bad++; $display("FAIL repress x=%0d sp=%0d want 344 1", SpriteX, Speed); end
  endtask

  task automatic test_top_bounce_reset();
    do_reset();
    step(8'h16);
    step(8'h2C);
    for (int i = 0; i < 25; i++) step(8'h1A);
    total++; if (SpriteY !== 10'd189 || Speed !== 4'd4) begin bad++; $display("FAIL tb_pre y=%0d sp=%0d want 189 4", SpriteY, Speed); end
    for (int i = 0; i < 43; i++) step(8'h00);
    total++; if (SpriteY !== 10'd17 || Bounce !== 1'b0) begin bad++; $display("FAIL tb_y17 y=%0d bnc=%0b want 17 0", SpriteY, Bounce); end
    step(8'h00);
    total++; if (SpriteY !== 10'd16 || Bounce !== 1'b1 || Speed !== 4'd4) begin bad++; $display("FAIL tb_hit y=%0d bnc=%0b sp=%0d want 16 1 4", SpriteY, Bounce, Speed); end
    step(8'h00);
    total++; if (SpriteY !== 10'd20 || Bounce !== 1'b0) begin bad++; $display("FAIL tb_after y=%0d bnc=%0b want 20 0", SpriteY, Bounce); end
    step(8'h16, 1);
    total++; if ({SpriteX, SpriteY, Speed, Moving, Bounce} !== {10'd320, 10'd240, 4'd0, 2'b00}) begin bad++; $display("FAIL rst_mid x=%0d y=%0d sp=%0d mov=%0b bnc=%0b want 320 240 0 0 0", SpriteX, SpriteY, Speed, Moving, Bounce); end
    step(8'h00);
    total++; if (SpriteY !== 10'd240 || Moving !== 1'b0) begin bad++; $display("FAIL rst_hold y=%0d mov=%0b want 240 0", SpriteY, Moving); end
  endtask

  task automatic test_random();
    logic [7:0] keys [7] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C, 8'h00, 8'h55};
    logic [7:0] k = 8'h07;
    int errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 8) k = keys[$urandom_range(6)];
      step(k, $urandom_range(499) == 0);
      total++;
      if ({SpriteX, SpriteY, Speed, Moving, Bounce} !== {10'(mx), 10'(my), 4'(msp), 1'(mmov), 1'(mbnc)}) begin
        bad++;
        if (errs++ < 10) $display("FAIL rand_%0d x=%0d y=%0d sp=%0d mov=%0b bnc=%0b want %0d %0d %0d %0d %0d", i, SpriteX, SpriteY, Speed, Moving, Bounce, mx, my, msp, mmov, mbnc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_accel();
    test_coast_stop();
    test_right_bounce();
    test_turns();
    test_top_bounce_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
